// File: rtl/register_file_multi_port_write_32b_1r_64b_if.sv
// rtl/register_file_multi_port_write_32b_1r_64b_if.sv - multi-port 32b write / single 64b read bus
interface register_file_multi_port_write_32b_1r_64b_if #(
  parameter int RADDR_WIDTH = 5,
  parameter int WADDR_WIDTH = RADDR_WIDTH + 1,
  parameter int WDATA_WIDTH = 32,
  parameter int N_WRITE     = 4
);
  logic [N_WRITE-1:0]                      WriteReq;
  logic [N_WRITE-1:0][WADDR_WIDTH-1:0]     WriteAddr;
  logic [N_WRITE-1:0][WDATA_WIDTH-1:0]     WriteData;
  logic [N_WRITE-1:0][WDATA_WIDTH/8-1:0]   WriteBE;
  logic [N_WRITE-1:0]                      WriteGnt;
  logic                                    ReadEnable;
  logic [RADDR_WIDTH-1:0]                  ReadAddr;
  logic [2*WDATA_WIDTH-1:0]                ReadData;

  modport master (
    output WriteReq, WriteAddr, WriteData, WriteBE, ReadEnable, ReadAddr,
    input  WriteGnt, ReadData
  );

  modport slave (
    input  WriteReq, WriteAddr, WriteData, WriteBE, ReadEnable, ReadAddr,
    output WriteGnt, ReadData
  );
endinterface

// File: rtl/register_file_multi_port_write_32b_1r_64b.sv
// rtl/register_file_multi_port_write_32b_1r_64b.sv - N x 32b write ports into a lo/hi banked 64b store, one registered 64b read
module register_file_multi_port_write_32b_1r_64b #(
  parameter int RADDR_WIDTH = 5,
  parameter int WADDR_WIDTH = RADDR_WIDTH + 1,
  parameter int WDATA_WIDTH = 32,
  parameter int RDATA_WIDTH = 2 * WDATA_WIDTH,
  parameter int N_WRITE     = 4,
  parameter int N_ROWS      = 2 ** RADDR_WIDTH
) (
  input  logic clk,
  input  logic rst_n,
  register_file_multi_port_write_32b_1r_64b_if.slave bus
);
  localparam int PTR_W   = (N_WRITE > 1) ? $clog2(N_WRITE) : 1;
  localparam int N_BYTES = WDATA_WIDTH / 8;

  logic [WDATA_WIDTH-1:0] lo_mem_q [N_ROWS];
  logic [WDATA_WIDTH-1:0] hi_mem_q [N_ROWS];

  logic [PTR_W-1:0]       lo_ptr_q, lo_ptr_d, hi_ptr_q, hi_ptr_d;
  logic [RDATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [N_WRITE-1:0]     lo_cand, hi_cand, gnt;
  logic                   lo_found, hi_found;
  logic [PTR_W-1:0]       lo_sel, hi_sel;
  logic [RADDR_WIDTH-1:0] lo_row, hi_row;
  logic [WDATA_WIDTH-1:0] lo_wdata, hi_wdata;
  logic [N_BYTES-1:0]     lo_wbe, hi_wbe;

  // Modulo-N_WRITE add; N_WRITE need not be a power of two.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p, input int j);
    int s;
    s = int'(p) + j;
    if (s >= N_WRITE) s = s - N_WRITE;
    return s[PTR_W-1:0];
  endfunction

  function automatic void arbitrate(input  logic [N_WRITE-1:0] cand,
                                    input  logic [PTR_W-1:0]   ptr,
                                    output logic               found,
                                    output logic [PTR_W-1:0]   sel);
    logic [PTR_W-1:0] k;
    found = 1'b0;
    sel   = ptr;
    for (int j = 0; j < N_WRITE; j++) begin
      k = wrap_add(ptr, j);
      if (!found && cand[k]) begin
        found = 1'b1;
        sel   = k;
      end
    end
  endfunction

  always_comb begin
    lo_cand = '0;
    hi_cand = '0;
    for (int i = 0; i < N_WRITE; i++) begin
      lo_cand[i] = bus.WriteReq[i] & ~bus.WriteAddr[i][0];
      hi_cand[i] = bus.WriteReq[i] &  bus.WriteAddr[i][0];
    end

    arbitrate(lo_cand, lo_ptr_q, lo_found, lo_sel);
    arbitrate(hi_cand, hi_ptr_q, hi_found, hi_sel);

    gnt = '0;
    if (lo_found) gnt[lo_sel] = 1'b1;
    if (hi_found) gnt[hi_sel] = 1'b1;

    lo_ptr_d = lo_found ? wrap_add(lo_sel, 1) : lo_ptr_q;
    hi_ptr_d = hi_found ? wrap_add(hi_sel, 1) : hi_ptr_q;

    lo_row   = bus.WriteAddr[lo_sel][WADDR_WIDTH-1:1];
    hi_row   = bus.WriteAddr[hi_sel][WADDR_WIDTH-1:1];
    lo_wdata = bus.WriteData[lo_sel];
    hi_wdata = bus.WriteData[hi_sel];
    lo_wbe   = bus.WriteBE[lo_sel];
    hi_wbe   = bus.WriteBE[hi_sel];

    // Read-first: the row is sampled before this edge's writes land.
    rdata_d = bus.ReadEnable ? {hi_mem_q[bus.ReadAddr], lo_mem_q[bus.ReadAddr]} : rdata_q;
  end

  assign bus.WriteGnt = gnt;
  assign bus.ReadData = rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_ptr_q <= '0;
      hi_ptr_q <= '0;
      rdata_q  <= '0;
    end else begin
      lo_ptr_q <= lo_ptr_d;
      hi_ptr_q <= hi_ptr_d;
      rdata_q  <= rdata_d;
    end
  end

  // Storage is not reset; rst_n only blocks commits.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int b = 0; b < N_BYTES; b++) begin
        if (lo_found && lo_wbe[b]) lo_mem_q[lo_row][8*b +: 8] <= lo_wdata[8*b +: 8];
        if (hi_found && hi_wbe[b]) hi_mem_q[hi_row][8*b +: 8] <= hi_wdata[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_register_file_multi_port_write_32b_1r_64b.sv
// tb/tb_register_file_multi_port_write_32b_1r_64b.sv - scoreboard bench for the banked multi-write register file
module tb_register_file_multi_port_write_32b_1r_64b;
  localparam int RAW = 5;
  localparam int WAW = 6;
  localparam int NW  = 4;
  localparam logic [63:0] M_ALL = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] M_LO  = 64'h0000_0000_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  register_file_multi_port_write_32b_1r_64b_if #(
    .RADDR_WIDTH(RAW), .WADDR_WIDTH(WAW), .WDATA_WIDTH(32), .N_WRITE(NW)
  ) bus ();

  register_file_multi_port_write_32b_1r_64b #(
    .RADDR_WIDTH(RAW), .WADDR_WIDTH(WAW), .N_WRITE(NW)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [63:0] data;
    logic [63:0] mask;
  } rd_exp_t;

  rd_exp_t    rd_q[$];
  logic [3:0] gnt_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.WriteReq   = '0;
    bus.WriteAddr  = '0;
    bus.WriteData  = '0;
    bus.WriteBE    = '0;
    bus.ReadEnable = 1'b0;
    bus.ReadAddr   = '0;
  endtask

  task automatic wr(input int p, input logic [WAW-1:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.WriteReq[p]  = 1'b1;
    bus.WriteAddr[p] = a;
    bus.WriteData[p] = d;
    bus.WriteBE[p]   = be;
  endtask

  task automatic rd(input logic [RAW-1:0] a, input logic [63:0] e, input logic [63:0] m);
    rd_exp_t x;
    bus.ReadEnable = 1'b1;
    bus.ReadAddr   = a;
    x.data = e & m;
    x.mask = m;
    rd_q.push_back(x);
  endtask

  task automatic step(input logic [3:0] exp_gnt);
    if (bus.WriteReq != '0) gnt_q.push_back(exp_gnt);
    @(posedge clk);
    #1;
    idle();
  endtask

  // Monitor: grants are checked every cycle with a live request, read data one cycle after a strobe.
  logic       rd_pending = 1'b0;
  logic [3:0] eg;
  rd_exp_t    er;

  always @(posedge clk) rd_pending <= rst_n && bus.ReadEnable;

  always @(negedge clk) begin
    if (rst_n && bus.WriteReq != '0) begin
      if (gnt_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL gnt_unexpected: got %b expected no request", bus.WriteGnt);
      end else begin
        eg = gnt_q.pop_front();
        chk("gnt", {60'd0, bus.WriteGnt}, {60'd0, eg});
      end
    end
    if (rd_pending) begin
      if (rd_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rdata_unexpected: got %h expected no read", bus.ReadData);
      end else begin
        er = rd_q.pop_front();
        chk("rdata", bus.ReadData & er.mask, er.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rdata", bus.ReadData, 64'd0);
    chk("reset_gnt", {60'd0, bus.WriteGnt}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // First request after reset, then prove lo pointer is 3
    wr(2, 6'd0, 32'h1234_5678, 4'hF); step(4'b0100);
    wr(0, 6'd2, 32'h5555_5555, 4'hF);
    wr(3, 6'd8, 32'h3333_3333, 4'hF); step(4'b1000);

    // Contention on lo bank from pointer 0
    wr(0, 6'd0, 32'hA0A0_A0A0, 4'hF); wr(1, 6'd2, 32'hA1A1_A1A1, 4'hF);
    wr(3, 6'd4, 32'hA3A3_A3A3, 4'hF); step(4'b0001);
    wr(1, 6'd2, 32'hA1A1_A1A1, 4'hF); wr(3, 6'd4, 32'hA3A3_A3A3, 4'hF); step(4'b0010);
    wr(3, 6'd4, 32'hA3A3_A3A3, 4'hF); step(4'b1000);
    rd(5'd0, 64'hA0A0_A0A0, M_LO); step(4'b0000);
    rd(5'd1, 64'hA1A1_A1A1, M_LO); step(4'b0000);
    rd(5'd2, 64'hA3A3_A3A3, M_LO); step(4'b0000);

    // Single-port fill of row 3
    wr(0, 6'd6, 32'hDEAD_BEEF, 4'hF); step(4'b0001);
    wr(0, 6'd7, 32'hCAFE_F00D, 4'hF); step(4'b0001);
    rd(5'd3, 64'hCAFE_F00D_DEAD_BEEF, M_ALL); step(4'b0000);

    // Parallel lo/hi writes to row 5
    wr(1, 6'd10, 32'h1111_1111, 4'hF); wr(2, 6'd11, 32'h2222_2222, 4'hF); step(4'b0110);
    rd(5'd5, 64'h2222_2222_1111_1111, M_ALL); step(4'b0000);

    // Byte enables with a same-cycle read of the same row
    wr(2, 6'd10, 32'hAABB_CCDD, 4'b0101);
    rd(5'd5, 64'h2222_2222_1111_1111, M_ALL); step(4'b0100);
    rd(5'd5, 64'h2222_2222_11BB_11DD, M_ALL); step(4'b0000);

    // BE=0000 consumes the grant and moves the pointer from 3 to 1
    wr(0, 6'd10, 32'hFFFF_FFFF, 4'b0000); step(4'b0001);
    rd(5'd5, 64'h2222_2222_11BB_11DD, M_ALL); step(4'b0000);
    wr(0, 6'd12, 32'hEEEE_EEEE, 4'hF); wr(1, 6'd14, 32'h7777_7777, 4'hF); step(4'b0010);

    // Reset mid-operation with lo pointer at 2
    wr(3, 6'd14, 32'hBADB_AD00, 4'hF);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_rdata", bus.ReadData, 64'd0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle();
    wr(3, 6'd8, 32'h4444_4444, 4'hF); step(4'b1000);
    rd(5'd7, 64'h7777_7777, M_LO); step(4'b0000);
    rd(5'd4, 64'h4444_4444, M_LO); step(4'b0000);

    // Both pointers back at 0: ports 1 and 3 compete, port 1 wins
    wr(1, 6'd16, 32'h0101_0101, 4'hF); wr(3, 6'd18, 32'h0303_0303, 4'hF); step(4'b0010);
    wr(1, 6'd17, 32'h1010_1010, 4'hF); wr(3, 6'd19, 32'h3030_3030, 4'hF); step(4'b0010);
    rd(5'd8, 64'h1010_1010_0101_0101, M_ALL); step(4'b0000);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("gnt_q_drained", 64'(gnt_q.size()), 64'd0);
    chk("rd_q_drained", 64'(rd_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
